atanh_approx_4bit_stream: RTL and testbench
===========================================

ATANH_APPROX_4BIT_STREAM -- requirements
Module: atanh_approx_4bit_stream

Interface
REQ-001 Parameter ROUND_MODE, default 1: selects the mapping table; 1 = round-to-nearest (half-up), 0 = truncate.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port In, input, 4 bits: tanh-domain code, unsigned Q0.4 (y = In/16).
REQ-005 Port in_valid, input, 1 bit: In is valid this cycle.
REQ-006 Port in_ready, output, 1 bit: block accepts In this cycle.
REQ-007 Port Out1, output, 4 bits: atanh-domain code, unsigned Q2.2 (x = Out1/4).
REQ-008 Port out_valid, output, 1 bit: Out1 is valid.
REQ-009 Port out_ready, input, 1 bit: downstream accepts Out1.
REQ-010 Port sat, output, 1 bit: the current Out1 came from In = 15 (the table clips at y = 1).
REQ-011 Port count, output, 8 bits: number of completed output transfers, modulo 256.

Function
REQ-012 An input transfer occurs when in_valid and in_ready are both 1 on a rising edge; an output transfer occurs when out_valid and out_ready are both 1.
REQ-013 Out1 = table[In], indexed by In = 0..15:
- ROUND_MODE = 1: 0,0,1,1,1,1,2,2,2,3,3,3,4,5,5,7.
- ROUND_MODE = 0: 0,0,0,0,1,1,1,1,2,2,2,3,3,4,5,6.
REQ-014 Both tables are fixed constants equal to round/floor(4*atanh(In/16)); there is no runtime arithmetic.
REQ-015 The datapath is a two-stage pipeline:
- S1 registers In.
- S2 registers table[S1] and sat.
- Each stage has its own valid bit.
REQ-016 S2 loads when S1 is valid and (S2 is empty or an output transfer occurs in the same cycle).
REQ-017 S1 loads when an input transfer occurs.
REQ-018 in_ready = !S1_valid or S1 advances into S2 in the same cycle, so a full pipeline under out_ready = 1 sustains one transfer per cycle.
REQ-019 Latency: 2 cycles from an input transfer to out_valid when there is no backpressure.
REQ-020 While out_valid = 1 and out_ready = 0, Out1 and sat hold stable and no data is lost or duplicated.
REQ-021 With both stages full and out_ready = 0, in_ready = 0.
REQ-022 If an output transfer and an S1->S2 advance happen in the same cycle, S2 takes the new value and out_valid stays 1.
REQ-023 count increments by 1 per output transfer, wrapping from 255 to 0.
REQ-024 Out1, sat and count are combinationally independent of In; only in_ready depends combinationally on out_ready.

Reset
REQ-025 While rst_n = 0, all of the following hold immediately and asynchronously:
- S1_valid = S2_valid = 0, so out_valid = 0.
- Out1 = 0, sat = 0, count = 0.
- in_ready = 1.
REQ-026 A reset asserted mid-stream discards all in-flight samples.
REQ-027 After rst_n deasserts, the first input transfer may occur on the next rising edge.

Verification
REQ-028 Sweep: ROUND_MODE = 1, out_ready = 1, In = 0..15 on consecutive cycles.
- Out1 = 0,0,1,1,1,1,2,2,2,3,3,3,4,5,5,7, starting 2 cycles after the first input.
- out_valid is continuous for 16 cycles; count ends at 16; sat = 1 only on the last output.
REQ-029 Truncate table: ROUND_MODE = 0, In = 3, 12, 15 -> Out1 = 0, 3, 6.
REQ-030 Backpressure: out_ready = 0 with In = 9, 13, 14 offered back to back.
- Out1 holds at 3 with out_valid = 1; in_ready drops to 0 after two accepts.
- After out_ready = 1, the outputs are 3 then 5; In = 14 is then accepted and yields 5; none lost, none duplicated.
REQ-031 Wrap: 256 output transfers -> count returns to 0; the 257th transfer gives count = 1.
REQ-032 Mid-stream reset: pulse rst_n low with both stages full.
- out_valid, Out1, sat and count are 0 before the next clock edge; in_ready = 1.
- No stale sample appears after release.
REQ-033 Random: random in_valid and out_ready for 10k cycles -> outputs match a reference queue in order, and count equals the number of output transfers mod 256.

Source files
------------

// File: rtl/atanh_approx_4bit_stream.sv
// atanh_approx_4bit_stream
// Streaming atanh approximation: maps an unsigned Q0.4 tanh-domain code to an
// unsigned Q2.2 atanh-domain code through a fixed lookup table. A two-stage
// valid/ready pipeline sustains one sample per cycle and holds its output
// stable under backpressure.
module atanh_approx_4bit_stream #(
    parameter int ROUND_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] In,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] Out1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sat,
    output logic [7:0] count
);

    // Fixed tables of round/floor(4*atanh(In/16)); In = 15 clips at y = 1.
    function automatic logic [3:0] atanh_lut(input logic [3:0] code);
        logic [3:0] r;
        r = '0;
        if (ROUND_MODE == 1) begin
            case (code)
                4'd0, 4'd1:               r = 4'd0;
                4'd2, 4'd3, 4'd4, 4'd5:   r = 4'd1;
                4'd6, 4'd7, 4'd8:         r = 4'd2;
                4'd9, 4'd10, 4'd11:       r = 4'd3;
                4'd12:                    r = 4'd4;
                4'd13, 4'd14:             r = 4'd5;
                default:                  r = 4'd7;
            endcase
        end else begin
            case (code)
                4'd0, 4'd1, 4'd2, 4'd3:   r = 4'd0;
                4'd4, 4'd5, 4'd6, 4'd7:   r = 4'd1;
                4'd8, 4'd9, 4'd10:        r = 4'd2;
                4'd11, 4'd12:             r = 4'd3;
                4'd13:                    r = 4'd4;
                4'd14:                    r = 4'd5;
                default:                  r = 4'd6;
            endcase
        end
        return r;
    endfunction

    logic [3:0] s1_data;
    logic       s1_valid;
    logic       s2_valid;
    logic       s2_load;
    logic       in_xfer;
    logic       out_xfer;

    assign out_valid = s2_valid;
    assign out_xfer  = s2_valid && out_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign in_xfer   = in_valid && in_ready;

    // Stage 1: capture the raw input code on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_data  <= In;
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: register the looked-up result and saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out1     <= '0;
            sat      <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                Out1     <= atanh_lut(s1_data);
                sat      <= (s1_data == 4'd15);
                s2_valid <= 1'b1;
            end else if (out_xfer) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Completed output transfers, wrapping modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (out_xfer) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: tb/tb_atanh_approx_4bit_stream.sv
// Testbench for atanh_approx_4bit_stream: directed scenarios plus a random
// stream, with a scoreboard queue checking every output transfer in order.
module tb_atanh_approx_4bit_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] In = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] Out1;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       sat;
    logic [7:0] count;

    logic [3:0] in0 = '0;
    logic       in_valid0 = 1'b0;
    logic       in_ready0;
    logic [3:0] out1_0;
    logic       out_valid0;
    logic       out_ready0 = 1'b0;
    logic       sat0;
    logic [7:0] count0;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] tbl_round [16] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                                   4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd7};

    logic [4:0] sb[$];
    logic [7:0] exp_count = '0;

    atanh_approx_4bit_stream #(.ROUND_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .In(In), .in_valid(in_valid), .in_ready(in_ready),
        .Out1(Out1), .out_valid(out_valid), .out_ready(out_ready), .sat(sat), .count(count)
    );

    atanh_approx_4bit_stream #(.ROUND_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .In(in0), .in_valid(in_valid0), .in_ready(in_ready0),
        .Out1(out1_0), .out_valid(out_valid0), .out_ready(out_ready0), .sat(sat0), .count(count0)
    );

    always #5 clk = ~clk;

    // Scoreboard: push expectations on input transfers, pop on output transfers.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst_n) begin
            sb.delete();
            exp_count = '0;
        end else begin
            n_checks++;
            if (count !== exp_count) begin
                n_fail++;
                $display("FAIL sb_count: got %0d expected %0d at %0t", count, exp_count, $time);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got Out1=%0d sat=%0d expected no output at %0t", Out1, sat, $time);
                end else begin
                    e = sb.pop_front();
                    if ({sat, Out1} !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: got sat=%0d Out1=%0d expected sat=%0d Out1=%0d at %0t",
                                 sat, Out1, e[4], e[3:0], $time);
                    end
                end
                exp_count = exp_count + 8'd1;
            end
            if (in_valid && in_ready)
                sb.push_back({In == 4'd15, tbl_round[In]});
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0d expected 0", out_valid); end
        n_checks++; if (Out1 !== 4'd0) begin n_fail++; $display("FAIL rst_out1: got %0d expected 0", Out1); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat: got %0d expected 0", sat); end
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0d expected 1", in_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        int unsigned k;
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            in_valid = (j < 16);
            In = 4'(j);
            @(negedge clk);
            n_checks++;
            if (out_valid !== (j >= 2 && j < 18)) begin
                n_fail++;
                $display("FAIL sweep_valid[%0d]: got %0d expected %0d", j, out_valid, (j >= 2 && j < 18));
            end
            if (j >= 2 && j < 18) begin
                k = j - 2;
                n_checks++;
                if (Out1 !== tbl_round[k] || sat !== (k == 15)) begin
                    n_fail++;
                    $display("FAIL sweep_data[%0d]: got Out1=%0d sat=%0d expected Out1=%0d sat=%0d",
                             k, Out1, sat, tbl_round[k], (k == 15));
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (count !== 8'd16) begin n_fail++; $display("FAIL sweep_count: got %0d expected 16", count); end
    endtask

    task automatic test_truncate();
        logic [3:0] tv [3] = '{4'd3, 4'd12, 4'd15};
        logic [3:0] te [3] = '{4'd0, 4'd3, 4'd6};
        out_ready0 = 1'b1;
        for (int j = 0; j < 7; j++) begin
            in_valid0 = (j < 3);
            if (j < 3) in0 = tv[j];
            @(negedge clk);
            n_checks++;
            if (out_valid0 !== (j >= 2 && j < 5)) begin
                n_fail++;
                $display("FAIL trunc_valid[%0d]: got %0d expected %0d", j, out_valid0, (j >= 2 && j < 5));
            end
            if (j >= 2 && j < 5) begin
                n_checks++;
                if (out1_0 !== te[j-2] || sat0 !== (j == 4)) begin
                    n_fail++;
                    $display("FAIL trunc_data[%0d]: got Out1=%0d sat=%0d expected Out1=%0d sat=%0d",
                             j - 2, out1_0, sat0, te[j-2], (j == 4));
                end
            end
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] offers [3] = '{4'd9, 4'd13, 4'd14};
        int idx = 0;
        for (int j = 0; j < 11; j++) begin
            out_ready = (j >= 6);
            in_valid = (idx < 3);
            if (idx < 3) In = offers[idx];
            @(negedge clk);
            if (j >= 2 && j <= 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || Out1 !== 4'd3 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: got valid=%0d Out1=%0d in_ready=%0d expected 1,3,0",
                             j, out_valid, Out1, in_ready);
                end
            end
            if (j == 6) begin
                n_checks++;
                if (Out1 !== 4'd3 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_release: got Out1=%0d in_ready=%0d expected 3,1", Out1, in_ready);
                end
            end
            if (j == 7 || j == 8) begin
                n_checks++;
                if (out_valid !== 1'b1 || Out1 !== 4'd5) begin
                    n_fail++;
                    $display("FAIL bp_drain[%0d]: got valid=%0d Out1=%0d expected 1,5", j, out_valid, Out1);
                end
            end
            if (j == 9) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0d expected 0", out_valid); end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (idx != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 3", idx); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 260; j++) begin
            in_valid = (j < 256);
            In = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 8'd0) begin n_fail++; $display("FAIL wrap_256: got %0d expected 0", count); end
        @(posedge clk); #1;
        in_valid = 1'b1;
        In = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (count !== 8'd1) begin n_fail++; $display("FAIL wrap_257: got %0d expected 1", count); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        In = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sat !== 1'b1 || Out1 !== 4'd7 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_full: got valid=%0d sat=%0d Out1=%0d in_ready=%0d expected 1,1,7,0",
                     out_valid, sat, Out1, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || Out1 !== 4'd0 || sat !== 1'b0 || count !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_async: got valid=%0d Out1=%0d sat=%0d count=%0d in_ready=%0d expected 0,0,0,0,1",
                     out_valid, Out1, sat, count, in_ready);
        end
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_stale[%0d]: got %0d expected 0", j, out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int j = 0; j < 10000; j++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            In = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending expected 0", sb.size()); end
        n_checks++;
        if (count !== exp_count) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_truncate();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
